// File: rtl/sort4_stage.sv
`default_nettype none
// ============================================================================
//  Module      : sort4_stage
//  Description : Collects WIDTH-bit samples into groups of four, sorts each
//                group ascending with a three-stage pipelined comparator
//                network and presents it with merge-stage load strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module sort4_stage #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sync,
  input  logic [WIDTH-1:0]   in_data,
  output logic [4*WIDTH-1:0] inba,
  output logic [1:0]         load4to8,
  output logic [1:0]         load8to16,
  output logic               frame_done
);

  localparam logic [1:0] c_pair_first  = 2'b01;
  localparam logic [1:0] c_pair_second = 2'b10;
  localparam logic [1:0] c_none        = 2'b00;

  // Element 0 sits in the low bits so the packed vector maps directly to inba.
  typedef logic [3:0][WIDTH-1:0] vec_t;

  logic [1:0] r_ecnt;
  logic [1:0] r_gcnt;
  vec_t       r_slot;

  // Hand-off register between collection and stage A.
  logic       r_g_vld;
  logic [1:0] r_g_tag;
  vec_t       r_g;

  logic       r_a_vld, r_b_vld, r_c_vld;
  logic [1:0] r_a_tag, r_b_tag, r_c_tag;
  vec_t       r_a, r_b, r_c;

  vec_t       w_a, w_b, w_c;

  // Collection: fill slots, hand a complete group plus its tag to the sorter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ecnt  <= 2'd0;
      r_gcnt  <= 2'd0;
      r_slot  <= '0;
      r_g_vld <= 1'b0;
      r_g_tag <= 2'd0;
      r_g     <= '0;
    end else begin
      r_g_vld <= 1'b0;
      if (in_valid) begin
        if (in_sync) begin
          // New frame: drop any partial group, restart at element 0 of group 0.
          r_slot[0] <= in_data;
          r_ecnt    <= 2'd1;
          r_gcnt    <= 2'd0;
        end else begin
          r_slot[r_ecnt] <= in_data;
          r_ecnt         <= r_ecnt + 2'd1;
          if (r_ecnt == 2'd3) begin
            r_g[0]  <= r_slot[0];
            r_g[1]  <= r_slot[1];
            r_g[2]  <= r_slot[2];
            r_g[3]  <= in_data;
            r_g_vld <= 1'b1;
            r_g_tag <= r_gcnt;
            r_gcnt  <= r_gcnt + 2'd1;
          end
        end
      end
    end
  end

  // Stage A network: compare-exchange (0,1) and (2,3).
  always_comb begin
    w_a = r_g;
    if (r_g[1] < r_g[0]) begin
      w_a[0] = r_g[1];
      w_a[1] = r_g[0];
    end
    if (r_g[3] < r_g[2]) begin
      w_a[2] = r_g[3];
      w_a[3] = r_g[2];
    end
  end

  // Stage B network: compare-exchange (0,2) and (1,3).
  always_comb begin
    w_b = r_a;
    if (r_a[2] < r_a[0]) begin
      w_b[0] = r_a[2];
      w_b[2] = r_a[0];
    end
    if (r_a[3] < r_a[1]) begin
      w_b[1] = r_a[3];
      w_b[3] = r_a[1];
    end
  end

  // Stage C network: compare-exchange (1,2) finishes the sort.
  always_comb begin
    w_c = r_b;
    if (r_b[2] < r_b[1]) begin
      w_c[1] = r_b[2];
      w_c[2] = r_b[1];
    end
  end

  // Pipeline registers A/B/C; the tag travels with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
      r_c_vld <= 1'b0;
      r_a_tag <= 2'd0;
      r_b_tag <= 2'd0;
      r_c_tag <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      r_a_vld <= r_g_vld;
      r_b_vld <= r_a_vld;
      r_c_vld <= r_b_vld;
      r_a_tag <= r_g_tag;
      r_b_tag <= r_a_tag;
      r_c_tag <= r_b_tag;
      r_a     <= w_a;
      r_b     <= w_b;
      r_c     <= w_c;
    end
  end

  // Output register: one-cycle strobes, inba held until the next group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inba       <= '0;
      load4to8   <= c_none;
      load8to16  <= c_none;
      frame_done <= 1'b0;
    end else begin
      load4to8   <= c_none;
      load8to16  <= c_none;
      frame_done <= 1'b0;
      if (r_c_vld) begin
        inba       <= r_c;
        load4to8   <= r_c_tag[0] ? c_pair_second : c_pair_first;
        load8to16  <= (r_c_tag == 2'd2) ? c_pair_first :
                      (r_c_tag == 2'd3) ? c_pair_second : c_none;
        frame_done <= (r_c_tag == 2'd3);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort4_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort4_stage
//  Description : Scoreboard bench for sort4_stage; a reference model queues
//                expected groups, a monitor checks every output cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sort4_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_sync;
  logic [7:0]  in_data;
  logic [31:0] inba;
  logic [1:0]  load4to8;
  logic [1:0]  load8to16;
  logic        frame_done;

  sort4_stage #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .in_data    (in_data),
    .inba       (inba),
    .load4to8   (load4to8),
    .load8to16  (load8to16),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [31:0] inba;
    logic [1:0]  l48;
    logic [1:0]  l816;
    logic        fd;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          grp_q[$];
  int          gidx;
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic [31:0] hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sort the four samples with plain arithmetic, tag decides strobes.
  function automatic logic [31:0] sorted_pack(input int v0, input int v1, input int v2, input int v3);
    int v[4];
    int t;
    logic [31:0] r;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0 && v[j] < v[j-1]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    end
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = v[i][7:0];
    return r;
  endfunction

  task automatic model(input logic s, input logic [7:0] d);
    exp_t e;
    if (s) begin
      grp_q.delete();
      gidx = 0;
    end
    grp_q.push_back(int'(d));
    if (grp_q.size() == 4) begin
      e.inba = sorted_pack(grp_q[0], grp_q[1], grp_q[2], grp_q[3]);
      e.l48  = (gidx % 2 == 0) ? 2'b01 : 2'b10;
      e.l816 = (gidx == 2) ? 2'b01 : (gidx == 3) ? 2'b10 : 2'b00;
      e.fd   = (gidx == 3);
      e.due  = cyc + 5;
      sb.push_back(e);
      gidx = (gidx + 1) % 4;
      grp_q.delete();
    end
  endtask

  task automatic send(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    if (v) model(s, d);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    sb.delete();
    grp_q.delete();
    gidx = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every strobe must match the scoreboard head at its due cycle.
  initial begin
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = '0;
      end else begin
        if (load4to8 != 2'b00 || load8to16 != 2'b00 || frame_done) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got l48=%b l816=%b fd=%b required none (cycle %0d)",
                     load4to8, load8to16, frame_done, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("inba",       64'(inba),       64'(e.inba));
            check("load4to8",   64'(load4to8),   64'(e.l48));
            check("load8to16",  64'(load8to16),  64'(e.l816));
            check("frame_done", 64'(frame_done), 64'(e.fd));
            check("latency",    64'(cyc),        64'(e.due));
            hold = e.inba;
          end
        end else begin
          check("inba_hold", 64'(inba), 64'(hold));
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_strobe: got none required group due at cycle %0d (cycle %0d)",
                   sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  logic [7:0] frame_vals [16];

  initial begin
    logic v, s;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    gidx     = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_inba",       64'(inba),       64'h0);
    check("rst_load4to8",   64'(load4to8),   64'h0);
    check("rst_load8to16",  64'(load8to16),  64'h0);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Single group with explicit known result, strobes clear next cycle
    send(1, 1, 8'd10); send(1, 0, 8'd7); send(1, 0, 8'd9); send(1, 0, 8'd8);
    idle(5);
    check("single_inba",  64'(inba),     64'h0A090807);
    check("single_l48",   64'(load4to8), 64'h1);
    idle(1);
    check("single_l48_clear",  64'(load4to8),   64'h0);
    check("single_fd_clear",   64'(frame_done), 64'h0);
    check("single_inba_held",  64'(inba),       64'h0A090807);
    idle(4);

    // Full continuous frame
    frame_vals = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd23, 8'd20, 8'd22, 8'd21,
                   8'd34, 8'd31, 8'd33, 8'd32, 8'd44, 8'd41, 8'd43, 8'd42};
    for (int i = 0; i < 16; i++) send(1, (i == 0), frame_vals[i]);
    idle(5);
    check("frame_last_inba", 64'(inba),       64'h2C2B2A29);
    check("frame_last_fd",   64'(frame_done), 64'h1);
    check("frame_last_l816", 64'(load8to16),  64'h2);
    idle(4);

    // Gaps inside a group
    send(1, 1, 8'd10); send(1, 0, 8'd7); idle(3); send(1, 0, 8'd9); send(1, 0, 8'd8);
    idle(8);

    // Resync discards a partial group
    send(1, 0, 8'd100); send(1, 0, 8'd101);
    send(1, 1, 8'd5); send(1, 0, 8'd1); send(1, 0, 8'd3); send(1, 0, 8'd2);
    idle(5);
    check("resync_inba", 64'(inba),     64'h05030201);
    check("resync_l48",  64'(load4to8), 64'h1);
    idle(4);

    // Reset at E+2 of a group; next group is group 0
    send(1, 1, 8'd50); send(1, 0, 8'd60); send(1, 0, 8'd40); send(1, 0, 8'd30);
    idle(2);
    do_reset();
    idle(3);
    send(1, 0, 8'd4); send(1, 0, 8'd3); send(1, 0, 8'd2); send(1, 0, 8'd1);
    idle(5);
    check("postrst_inba", 64'(inba),     64'h04030201);
    check("postrst_l48",  64'(load4to8), 64'h1);
    idle(4);

    // Extremes and ties, unsigned ordering
    send(1, 1, 8'd255); send(1, 0, 8'd0); send(1, 0, 8'd255); send(1, 0, 8'd0);
    idle(5);
    check("extreme_inba", 64'(inba), 64'hFFFF0000);
    idle(4);

    // Randomized stream with gaps and occasional resync
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 24) == 0);
      send(v, s, 8'($urandom));
    end
    // Narrow value range to force ties
    for (int i = 0; i < 100; i++) begin
      send(1, 1'b0, 8'($urandom_range(0, 2)));
    end

    idle(10);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
